// File: rtl/vdp_vram_pkg.sv
// Shared types for the CPU-side VRAM write scheduler: queued write entry,
// scheduler state encoding and the legacy-mode address increment helper.
package vdp_vram_pkg;

    localparam logic [16:0] WRAP14_MASK = 17'h03FFF;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } vram_wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } sched_state_t;

    // Legacy screen modes only carry bits[13:0]; the upper bits stay put.
    function automatic logic [16:0] vram_addr_inc(input logic [16:0] a,
                                                  input logic        wrap,
                                                  input logic [1:0]  k);
        logic [16:0] sum;
        sum = a + {15'd0, k};
        return wrap ? ((a & ~WRAP14_MASK) | (sum & WRAP14_MASK)) : sum;
    endfunction

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous FIFO of pending CPU VRAM writes. The head entry stays in the
// FIFO while its access is in flight and is popped only on the arbiter ack.
module vram_req_fifo
    import vdp_vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           CLK21M,
    input  logic           RESET_N,
    input  logic           push,
    input  vram_wr_entry_t push_entry,
    input  logic           pop,
    output vram_wr_entry_t head,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    vram_wr_entry_t   mem [DEPTH];

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK21M) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/vram_cpu_write_scheduler.sv
// Buffers CPU port-0 VRAM writes/reads and hands them to the VRAM arbiter
// over the toggle req/ack handshake; owns the CPU VRAM address counter.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_IDLE    | no access outstanding; queued writes go before a read
//  ST_WR_WAIT | write request toggled, waiting for vram_wr_ack to match
//  ST_RD_WAIT | read request toggled, waiting for vram_rd_ack to match
module vram_cpu_write_scheduler
    import vdp_vram_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 17
) (
    input  logic              CLK21M,
    input  logic              RESET_N,
    input  logic              cpu_wr_stb,
    input  logic [7:0]        cpu_wr_data,
    input  logic              cpu_rd_stb,
    input  logic              addr_set_stb,
    input  logic [ADDR_W-1:0] addr_set_val,
    input  logic              wrap_14,
    input  logic              clr_err,
    input  logic              vram_wr_ack,
    input  logic              vram_rd_ack,
    output logic              vram_wr_req,
    output logic              vram_rd_req,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              rd_done,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              err_overflow,
    output logic              err_rd_overrun
);

    sched_state_t      state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pend;
    vram_wr_entry_t    head;
    vram_wr_entry_t    push_entry;
    logic              q_full;
    logic              q_empty;
    logic              wr_done;
    logic              rd_ack_hit;
    logic              rd_acc;
    logic              push;
    logic              ovf;

    assign wr_done    = (state == ST_WR_WAIT) && (vram_wr_ack == vram_wr_req);
    assign rd_ack_hit = (state == ST_RD_WAIT) && (vram_rd_ack == vram_rd_req);
    assign rd_acc     = cpu_rd_stb && !rd_pend;
    // The ack pop frees a slot in the same clock, so a full FIFO can still accept.
    assign push       = cpu_wr_stb && (!q_full || wr_done);
    assign ovf        = cpu_wr_stb && q_full && !wr_done;
    assign push_entry = '{addr: addr_cnt, data: cpu_wr_data};

    vram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK21M     (CLK21M),
        .RESET_N    (RESET_N),
        .push       (push),
        .push_entry (push_entry),
        .pop        (wr_done),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign fifo_full  = q_full;
    assign fifo_empty = q_empty && (state != ST_WR_WAIT);

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_cnt       <= '0;
            rd_addr        <= '0;
            rd_pend        <= 1'b0;
            err_overflow   <= 1'b0;
            err_rd_overrun <= 1'b0;
        end else begin
            if (addr_set_stb)
                addr_cnt <= addr_set_val;
            else
                addr_cnt <= vram_addr_inc(addr_cnt, wrap_14, {1'b0, cpu_wr_stb} + {1'b0, rd_acc});

            // A read issued with a write in the same clock targets the address after it.
            if (rd_acc) begin
                rd_pend <= 1'b1;
                rd_addr <= vram_addr_inc(addr_cnt, wrap_14, {1'b0, cpu_wr_stb});
            end else if (rd_ack_hit) begin
                rd_pend <= 1'b0;
            end

            if (ovf)          err_overflow <= 1'b1;
            else if (clr_err) err_overflow <= 1'b0;

            if (cpu_rd_stb && rd_pend) err_rd_overrun <= 1'b1;
            else if (clr_err)          err_rd_overrun <= 1'b0;
        end
    end

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            vram_wr_req <= 1'b0;
            vram_rd_req <= 1'b0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
            rd_done     <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        vram_addr   <= head.addr;
                        vram_wdata  <= head.data;
                        vram_wr_req <= ~vram_wr_req;
                        state       <= ST_WR_WAIT;
                    end else if (rd_pend) begin
                        vram_addr   <= rd_addr;
                        vram_rd_req <= ~vram_rd_req;
                        state       <= ST_RD_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_done) state <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (rd_ack_hit) begin
                        rd_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_cpu_write_scheduler.sv
// Scoreboard bench: stimulus pushes expected VRAM accesses, a monitor pops
// and compares them whenever the DUT toggles a request.
module tb_vram_cpu_write_scheduler;

    localparam int ACK_DLY = 3;

    logic        CLK21M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cpu_wr_stb = 1'b0;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic        cpu_rd_stb = 1'b0;
    logic        addr_set_stb = 1'b0;
    logic [16:0] addr_set_val = 17'h0;
    logic        wrap_14 = 1'b0;
    logic        clr_err = 1'b0;
    logic        vram_wr_ack;
    logic        vram_rd_ack;
    logic        vram_wr_req;
    logic        vram_rd_req;
    logic [16:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        rd_done;
    logic        fifo_full;
    logic        fifo_empty;
    logic        err_overflow;
    logic        err_rd_overrun;

    vram_cpu_write_scheduler #(.DEPTH(4), .ADDR_W(17)) dut (
        .CLK21M         (CLK21M),
        .RESET_N        (RESET_N),
        .cpu_wr_stb     (cpu_wr_stb),
        .cpu_wr_data    (cpu_wr_data),
        .cpu_rd_stb     (cpu_rd_stb),
        .addr_set_stb   (addr_set_stb),
        .addr_set_val   (addr_set_val),
        .wrap_14        (wrap_14),
        .clr_err        (clr_err),
        .vram_wr_ack    (vram_wr_ack),
        .vram_rd_ack    (vram_rd_ack),
        .vram_wr_req    (vram_wr_req),
        .vram_rd_req    (vram_rd_req),
        .vram_addr      (vram_addr),
        .vram_wdata     (vram_wdata),
        .rd_done        (rd_done),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .err_overflow   (err_overflow),
        .err_rd_overrun (err_rd_overrun)
    );

    always #5 CLK21M = ~CLK21M;

    typedef struct {
        bit          is_rd;
        logic [16:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_ack_cyc = -100;
    int  rd_ack_cyc = -100;
    int  rd_done_exp = 0;
    int  t_first_wr = -1;
    bit  hold_wr = 1'b0;
    logic prev_wr = 1'b0, prev_rd = 1'b0, prev_wr_ack = 1'b0, prev_rd_ack = 1'b0;
    int  wcnt, rcnt;

    always @(posedge CLK21M) cyc++;

    // Arbiter stand-in: answers each request toggle ACK_DLY clocks later.
    always @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            vram_wr_ack <= 1'b0;
            vram_rd_ack <= 1'b0;
            wcnt <= 0;
            rcnt <= 0;
        end else begin
            if (vram_wr_req != vram_wr_ack && !hold_wr) begin
                if (wcnt == ACK_DLY-1) begin vram_wr_ack <= vram_wr_req; wcnt <= 0; end
                else wcnt <= wcnt + 1;
            end
            if (vram_rd_req != vram_rd_ack) begin
                if (rcnt == ACK_DLY-1) begin vram_rd_ack <= vram_rd_req; rcnt <= 0; end
                else rcnt <= rcnt + 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge CLK21M) begin
        ev_t e;
        if (!RESET_N) begin
            prev_wr = vram_wr_req; prev_rd = vram_rd_req;
            prev_wr_ack = vram_wr_ack; prev_rd_ack = vram_rd_ack;
            last_ack_cyc = -100; rd_done_exp = 0;
        end else begin
            if (vram_wr_ack != prev_wr_ack || vram_rd_ack != prev_rd_ack) last_ack_cyc = cyc;
            if (vram_rd_ack != prev_rd_ack) rd_ack_cyc = cyc;
            prev_wr_ack = vram_wr_ack;
            prev_rd_ack = vram_rd_ack;
            if (vram_wr_req != prev_wr) begin
                prev_wr = vram_wr_req;
                if (t_first_wr < 0) t_first_wr = cyc;
                check("wr_req_gap", (cyc - last_ack_cyc) >= 2, 1);
                check("wr_req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_kind", e.is_rd, 0);
                    check("wr_addr", vram_addr, e.addr);
                    check("wr_data", vram_wdata, e.data);
                end
            end
            if (vram_rd_req != prev_rd) begin
                prev_rd = vram_rd_req;
                rd_done_exp++;
                check("rd_req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rd_kind", e.is_rd, 1);
                    check("rd_addr", vram_addr, e.addr);
                end
            end
            if (rd_done) begin
                check("rd_done_expected", rd_done_exp != 0, 1);
                check("rd_done_lat", cyc - rd_ack_cyc, 1);
                if (rd_done_exp > 0) rd_done_exp--;
            end
        end
    end

    task automatic exp_wr(input logic [16:0] a, input logic [7:0] d);
        ev_t e; e.is_rd = 1'b0; e.addr = a; e.data = d; exp_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [16:0] a);
        ev_t e; e.is_rd = 1'b1; e.addr = a; e.data = 8'h00; exp_q.push_back(e);
    endtask

    task automatic do_wr(input logic [7:0] d);
        cpu_wr_stb = 1'b1; cpu_wr_data = d;
        @(negedge CLK21M);
        cpu_wr_stb = 1'b0;
    endtask

    task automatic do_rd();
        cpu_rd_stb = 1'b1;
        @(negedge CLK21M);
        cpu_rd_stb = 1'b0;
    endtask

    task automatic set_addr(input logic [16:0] a);
        addr_set_stb = 1'b1; addr_set_val = a;
        @(negedge CLK21M);
        addr_set_stb = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge CLK21M);
        clr_err = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || !fifo_empty || rd_done_exp != 0 ||
                vram_rd_req != vram_rd_ack) && n < 200) begin
            @(negedge CLK21M);
            n++;
        end
        check(nm, n < 200, 1);
        repeat (3) @(negedge CLK21M);
    endtask

    initial begin
        int issue_cyc;
        repeat (2) @(negedge CLK21M);
        #1;
        check("rst_wr_req", vram_wr_req, 0);
        check("rst_rd_req", vram_rd_req, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_wdata", vram_wdata, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_full", fifo_full, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_err_ovf", err_overflow, 0);
        check("rst_err_rd", err_rd_overrun, 0);
        @(negedge CLK21M);
        RESET_N = 1'b1;
        @(negedge CLK21M);

        // back-to-back writes, each acked after 3 clocks
        set_addr(17'h00100);
        exp_wr(17'h00100, 8'hAA); exp_wr(17'h00101, 8'hBB); exp_wr(17'h00102, 8'hCC);
        t_first_wr = -1;
        issue_cyc = cyc;
        do_wr(8'hAA); do_wr(8'hBB); do_wr(8'hCC);
        wait_idle("t1_idle");
        check("t1_latency", t_first_wr - issue_cyc, 2);
        check("t1_empty", fifo_empty, 1);

        // 14-bit wrap vs full 17-bit increment
        wrap_14 = 1'b1;
        set_addr(17'h13FFF);
        exp_wr(17'h13FFF, 8'h11); exp_wr(17'h10000, 8'h22);
        do_wr(8'h11); do_wr(8'h22);
        wait_idle("t2a_idle");
        wrap_14 = 1'b0;
        set_addr(17'h13FFF);
        exp_wr(17'h13FFF, 8'h33); exp_wr(17'h14000, 8'h44);
        do_wr(8'h33); do_wr(8'h44);
        set_addr(17'h1FFFF);
        exp_wr(17'h1FFFF, 8'h55); exp_wr(17'h00000, 8'h66);
        do_wr(8'h55); do_wr(8'h66);
        wait_idle("t2b_idle");

        // overflow with ack held
        hold_wr = 1'b1;
        set_addr(17'h00300);
        exp_wr(17'h00300, 8'h01); exp_wr(17'h00301, 8'h02);
        exp_wr(17'h00302, 8'h03); exp_wr(17'h00303, 8'h04);
        for (int i = 1; i <= 5; i++) do_wr(8'(i));
        check("t3_full", fifo_full, 1);
        check("t3_err_ovf", err_overflow, 1);
        check("t3_not_empty", fifo_empty, 0);
        cpu_wr_stb = 1'b1; cpu_wr_data = 8'h06; clr_err = 1'b1;
        @(negedge CLK21M);
        cpu_wr_stb = 1'b0; clr_err = 1'b0;
        check("t3_err_wins_clr", err_overflow, 1);
        pulse_clr();
        check("t3_err_cleared", err_overflow, 0);
        hold_wr = 1'b0;
        wait_idle("t3_idle");
        exp_wr(17'h00306, 8'h07);
        do_wr(8'h07);
        wait_idle("t3b_idle");

        // read queued behind two writes
        hold_wr = 1'b1;
        set_addr(17'h00400);
        exp_wr(17'h00400, 8'h77); exp_wr(17'h00401, 8'h88); exp_rd(17'h00402);
        do_wr(8'h77); do_wr(8'h88); do_rd();
        repeat (5) @(negedge CLK21M);
        check("t4_rd_blocked", vram_rd_req, 0);
        do_rd();
        check("t4_err_rd", err_rd_overrun, 1);
        pulse_clr();
        check("t4_err_rd_clr", err_rd_overrun, 0);
        hold_wr = 1'b0;
        wait_idle("t4_idle");
        exp_wr(17'h00403, 8'h99);
        do_wr(8'h99);
        wait_idle("t4b_idle");

        // same-clock write + address load, then write + read together
        set_addr(17'h00050);
        exp_wr(17'h00050, 8'hA1); exp_wr(17'h00200, 8'hA2);
        cpu_wr_stb = 1'b1; cpu_wr_data = 8'hA1; addr_set_stb = 1'b1; addr_set_val = 17'h00200;
        @(negedge CLK21M);
        cpu_wr_stb = 1'b0; addr_set_stb = 1'b0;
        do_wr(8'hA2);
        wait_idle("t5_idle");
        set_addr(17'h00600);
        exp_wr(17'h00600, 8'hB1); exp_rd(17'h00601);
        cpu_wr_stb = 1'b1; cpu_wr_data = 8'hB1; cpu_rd_stb = 1'b1;
        @(negedge CLK21M);
        cpu_wr_stb = 1'b0; cpu_rd_stb = 1'b0;
        wait_idle("t5b_idle");

        // reset while a write is in flight with two queued behind it
        hold_wr = 1'b1;
        set_addr(17'h00700);
        exp_wr(17'h00700, 8'hC1);
        do_wr(8'hC1); do_wr(8'hC2); do_wr(8'hC3);
        repeat (3) @(negedge CLK21M);
        check("t6_in_flight", vram_wr_req != vram_wr_ack, 1);
        #2 RESET_N = 1'b0;
        #1;
        check("t6_async_wr_req", vram_wr_req, 0);
        check("t6_async_addr", vram_addr, 0);
        check("t6_async_empty", fifo_empty, 1);
        hold_wr = 1'b0;
        repeat (2) @(negedge CLK21M);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK21M);
        check("t6_empty_after", fifo_empty, 1);
        check("t6_no_req", vram_wr_req, 0);
        exp_wr(17'h00000, 8'h5A);
        do_wr(8'h5A);
        wait_idle("t6_idle");

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
